// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory with sub-word read-modify-write stores.
// Optional macro LSU_ALIGN_CHECK_EN: when defined, misaligned halfword/word accesses are reported as errors.
module load_store_unit #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state, state_next;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;

  logic [31:0] offset_addr;
  logic [31:0] req_index;
  logic        range_err, f3_err, align_err, req_err;
  logic        is_sw;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign offset_addr = req_addr - ADDR_BASE;
  assign req_index   = offset_addr >> 2;
  assign range_err   = (req_addr < ADDR_BASE) || (req_index >= DEPTH);
  assign f3_err      = req_we ? (req_funct3 > 3'd2)
                              : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
`ifdef LSU_ALIGN_CHECK_EN
  assign align_err   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign align_err   = 1'b0;
`endif
  assign req_err     = range_err || f3_err || align_err;

  assign is_sw       = lat_we && (lat_f3[1:0] == 2'b10);
  assign req_ready   = (state == IDLE);
  // Write strobe stays combinational so an asserted rst suppresses a write in the same cycle.
  assign mem_we      = ((state == ACCESS && is_sw) || state == WRITE) && !rst;

  // Halfword lane follows off[1] only; with alignment checks off, off[0] is simply ignored.
  always_comb begin
    byte_lane = mem_rdata[{lat_off, 3'b000} +: 8];
    half_lane = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_f3[1:0])
      2'b00:   load_ext = {{24{~lat_f3[2] & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{~lat_f3[2] & half_lane[15]}}, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  // mem_wdata still holds the request store data while in ACCESS.
  always_comb begin
    merged = mem_rdata;
    if (lat_f3[1:0] == 2'b00)
      merged[{lat_off, 3'b000} +: 8] = mem_wdata[7:0];
    else
      merged[{lat_off[1], 4'b0000} +: 16] = mem_wdata[15:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = (lat_we && !is_sw) ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_off   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_off   <= req_addr[1:0];
            mem_wdata <= req_we ? req_wdata : '0;
            if (!req_err) mem_addr <= req_index;
            rsp_err   <= req_err;
            rsp_rdata <= '0;
            rsp_valid <= req_err;
          end
        end
        ACCESS: begin
          if (!lat_we) rsp_rdata <= load_ext;
          if (lat_we && !is_sw) mem_wdata <= merged;
          rsp_valid <= (state_next == RESP);
        end
        WRITE: rsp_valid <= 1'b1;
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
